laser_pwm_driver: RTL and testbench

//  Output stage directly downstream of the PI controller: takes the signed 9-bit control word u,

---
 rtl/laser_pid_pkg.sv | 28 ++
 rtl/laser_pwm_driver_if.sv | 28 ++
 rtl/pwm_period_counter.sv | 28 ++
 rtl/laser_pwm_driver.sv | 139 +++++++++++++
 tb/tb_laser_pwm_driver.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pid_pkg.sv
// Shared definitions for the laser control loop: word widths, limit defaults, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: U_W (control word width), CNT_W_DEF/DUTY_W_DEF (period counter and duty widths),
//   OFFSET/DUTY_MIN/DUTY_MAX defaults shared with the PI controller bench, PWM FSM states.
package laser_pid_pkg;

  localparam int U_W          = 9;
  localparam int CNT_W_DEF    = 8;
  localparam int DUTY_W_DEF   = CNT_W_DEF + 1;
  localparam int OFFSET_DEF   = 128;
  localparam int DUTY_MIN_DEF = 0;
  localparam int DUTY_MAX_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_t;

  // Elaboration-time clamp, used for constants such as the reset value of the shadow duty.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/laser_pwm_driver_if.sv
// Bundle between the PI controller (master) and the laser PWM output stage (slave).
// Latency: n/a (wiring only).
// Backpressure: none; u_valid is a single-cycle qualifier, every valid word is accepted.
// Signals: u_in/u_valid/enable from the controller; pwm_out, sample_tick, duty_cur,
//   sat_hi, sat_lo back from the output stage.
interface laser_pwm_driver_if;
  import laser_pid_pkg::*;

  logic [U_W-1:0]        u_in;
  logic                  u_valid;
  logic                  enable;
  logic                  pwm_out;
  logic                  sample_tick;
  logic [DUTY_W_DEF-1:0] duty_cur;
  logic                  sat_hi;
  logic                  sat_lo;

  modport master (
    output u_in, u_valid, enable,
    input  pwm_out, sample_tick, duty_cur, sat_hi, sat_lo
  );

  modport slave (
    input  u_in, u_valid, enable,
    output pwm_out, sample_tick, duty_cur, sat_hi, sat_lo
  );

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with clear and run controls.
// Latency: cnt updates on the edge after run/clear; wrap is combinational from cnt.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), run (count enable), clear (force 0, wins over run),
//   cnt (current position), wrap (high during the last cycle of a counting period).
module pwm_period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Only a running counter can wrap; a held counter never signals end of period.
  assign wrap = run && (cnt == '1);

endmodule

// File: rtl/laser_pwm_driver.sv
// Laser PWM output stage: offsets/clamps the PI control word and drives a double-buffered PWM.
// Latency: pwm_out/sample_tick are registered, one cycle after the counter position they reflect.
// Backpressure: none; each u_valid word is captured, a later one in the same period overrides it.
// Ports: clk, reset (sync, active-high), bus (slave side of laser_pwm_driver_if).
module laser_pwm_driver
  import laser_pid_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OFFSET   = OFFSET_DEF,
  parameter int DUTY_MIN = DUTY_MIN_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  laser_pwm_driver_if.slave  bus
);

  localparam int DUTY_W = CNT_W + 1;
  // Sum width: enough headroom that sign-extended u plus OFFSET can never overflow.
  localparam int S_W    = CNT_W + 3;

  localparam logic signed [S_W-1:0] OFF_S  = S_W'(OFFSET);
  localparam logic signed [S_W-1:0] DMIN_S = S_W'(DUTY_MIN);
  localparam logic signed [S_W-1:0] DMAX_S = S_W'(DUTY_MAX);

  localparam logic [DUTY_W-1:0] SHADOW_RST = DUTY_W'(clamp_int(OFFSET, DUTY_MIN, DUTY_MAX));

  pwm_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic              cnt_run, cnt_clear, load_duty;

  logic [S_W-1:0]    u_ext;
  logic signed [S_W-1:0] s_sum;
  logic              clamp_hi, clamp_lo;
  logic [DUTY_W-1:0] duty_new;

  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] duty_cur;
  logic              pwm_q, tick_q, sat_hi_q, sat_lo_q;

  pwm_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .run   (cnt_run),
    .clear (cnt_clear),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Offset and clamp the incoming control word.
  always_comb begin
    u_ext    = {{(S_W-U_W){bus.u_in[U_W-1]}}, bus.u_in};
    s_sum    = $signed(u_ext) + OFF_S;
    clamp_hi = (s_sum > DMAX_S);
    clamp_lo = (s_sum < DMIN_S);
    if (clamp_hi) begin
      duty_new = DUTY_W'(DUTY_MAX);
    end else if (clamp_lo) begin
      duty_new = DUTY_W'(DUTY_MIN);
    end else begin
      duty_new = s_sum[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_run   = 1'b0;
    cnt_clear = 1'b0;
    load_duty = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.enable) begin
          state_nxt = RUN;
          load_duty = 1'b1;
        end
      end
      RUN: begin
        cnt_run = 1'b1;
        if (wrap) load_duty = 1'b1;
        if (!bus.enable) state_nxt = STOP;
      end
      STOP: begin
        cnt_run = 1'b1;
        if (bus.enable) begin
          // Re-enabled before the period ends: the frame continues without a gap.
          state_nxt = RUN;
          if (wrap) load_duty = 1'b1;
        end else if (wrap) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= SHADOW_RST;
      duty_cur <= '0;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      if (bus.u_valid) begin
        shadow   <= duty_new;
        sat_hi_q <= clamp_hi;
        sat_lo_q <= clamp_lo;
      end
      // A word arriving on the wrap cycle goes straight into the next period.
      if (load_duty) begin
        duty_cur <= (bus.u_valid && wrap) ? duty_new : shadow;
      end
      // Full-scale duty is 2**CNT_W, so the compare is one bit wider than cnt.
      pwm_q  <= (state != IDLE) && ({1'b0, cnt} < duty_cur);
      tick_q <= wrap;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.sample_tick = tick_q;
  assign bus.duty_cur    = duty_cur;
  assign bus.sat_hi      = sat_hi_q;
  assign bus.sat_lo      = sat_lo_q;

endmodule

// File: tb/tb_laser_pwm_driver.sv
// Bench for laser_pwm_driver: vector table for clamp/duty, hand sequences for corners,
// then random traffic against a behavioural frame model.
module tb_laser_pwm_driver;

  logic clk;
  logic reset;

  laser_pwm_driver_if bus();

  laser_pwm_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a frame is either off, running, or running its last period.
  bit m_on, m_stop, m_pwm, m_tick, m_hi, m_lo;
  int m_pos, m_shadow, m_duty;

  typedef struct {
    int u;
    int duty;
    int hi;
    int lo;
  } vec_t;

  vec_t vec[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input bit uv, input bit en, input bit rst);
    int s;
    int c;
    bit h;
    bit l;
    s = u + 128;
    h = (s > 256);
    l = (s < 0);
    c = h ? 256 : (l ? 0 : s);
    if (rst) begin
      m_on = 0; m_stop = 0; m_pos = 0; m_shadow = 128; m_duty = 0;
      m_pwm = 0; m_tick = 0; m_hi = 0; m_lo = 0;
      return;
    end
    m_pwm  = m_on && (m_pos < m_duty);
    m_tick = m_on && (m_pos == 255);
    if (!m_on) begin
      if (en) begin
        m_on = 1; m_stop = 0; m_pos = 0; m_duty = m_shadow;
      end
    end else begin
      if (m_pos == 255) begin
        if (!m_stop || en) m_duty = uv ? c : m_shadow;
        if (m_stop && !en) m_on = 0;
      end
      m_stop = !en;
      m_pos  = (m_pos + 1) % 256;
    end
    if (uv) begin
      m_shadow = c; m_hi = h; m_lo = l;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic cyc(input logic signed [8:0] u, input bit uv, input bit en, input bit rst);
    bus.u_in    = u;
    bus.u_valid = uv;
    bus.enable  = en;
    reset       = rst;
    @(posedge clk);
    model_step(int'(u), uv, en, rst);
    @(negedge clk);
    check("pwm_out", int'(bus.pwm_out), int'(m_pwm));
    check("sample_tick", int'(bus.sample_tick), int'(m_tick));
    check("duty_cur", int'(bus.duty_cur), m_duty);
    check("sat_hi", int'(bus.sat_hi), int'(m_hi));
    check("sat_lo", int'(bus.sat_lo), int'(m_lo));
  endtask

  task automatic run_to(input int pos, input bit en);
    int n;
    n = 0;
    while (m_pos != pos && n < 600) begin
      cyc(9'sd0, 1'b0, en, 1'b0);
      n++;
    end
    if (m_pos != pos) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to: position %0d expected %0d", m_pos, pos);
    end
  endtask

  task automatic count(input int n, input bit en, output int highs, output int ticks,
                       output int first_tick);
    highs = 0;
    ticks = 0;
    first_tick = -1;
    for (int k = 1; k <= n; k++) begin
      cyc(9'sd0, 1'b0, en, 1'b0);
      if (bus.pwm_out) highs++;
      if (bus.sample_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
    end
  endtask

  initial begin
    int highs, ticks, ft, prev;
    bit en;
    bit rst;
    bit uv;

    vec[0]  = '{100,  228, 0, 0};
    vec[1]  = '{0,    128, 0, 0};
    vec[2]  = '{127,  255, 0, 0};
    vec[3]  = '{128,  256, 0, 0};
    vec[4]  = '{255,  256, 1, 0};
    vec[5]  = '{-1,   127, 0, 0};
    vec[6]  = '{-128, 0,   0, 0};
    vec[7]  = '{-129, 0,   0, 1};
    vec[8]  = '{-256, 0,   0, 1};
    vec[9]  = '{-28,  100, 0, 0};
    vec[10] = '{50,   178, 0, 0};

    bus.u_in = '0; bus.u_valid = 1'b0; bus.enable = 1'b0; reset = 1'b1;

    // Reset state
    cyc(9'sd0, 1'b0, 1'b0, 1'b1);
    cyc(9'sd0, 1'b0, 1'b0, 1'b1);
    check("rst_duty", int'(bus.duty_cur), 0);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_tick", int'(bus.sample_tick), 0);
    check("rst_sat", int'({bus.sat_hi, bus.sat_lo}), 0);

    // Default duty from reset shadow: 50%, one tick per 256 cycles
    cyc(9'sd0, 1'b0, 1'b1, 1'b0);
    check("start_duty", int'(bus.duty_cur), 128);
    count(512, 1'b1, highs, ticks, ft);
    check("default_highs", highs, 256);
    check("default_ticks", ticks, 2);
    check("default_first_tick", ft, 256);

    // Clamp table: capture mid-period, previous duty holds until the wrap
    prev = 128;
    for (int i = 0; i < 11; i++) begin
      run_to(100, 1'b1);
      cyc(9'(vec[i].u), 1'b1, 1'b1, 1'b0);
      check("vec_sat_hi", int'(bus.sat_hi), vec[i].hi);
      check("vec_sat_lo", int'(bus.sat_lo), vec[i].lo);
      check("vec_duty_hold", int'(bus.duty_cur), prev);
      run_to(255, 1'b1);
      cyc(9'sd0, 1'b0, 1'b1, 1'b0);
      check("vec_duty_new", int'(bus.duty_cur), vec[i].duty);
      count(256, 1'b1, highs, ticks, ft);
      check("vec_highs", highs, vec[i].duty);
      check("vec_ticks", ticks, 1);
      prev = vec[i].duty;
    end

    // Word on the wrap cycle bypasses the shadow; earlier word in the period is lost
    run_to(30, 1'b1);
    cyc(9'sd60, 1'b1, 1'b1, 1'b0);
    run_to(255, 1'b1);
    cyc(-9'sd28, 1'b1, 1'b1, 1'b0);
    check("bypass_duty", int'(bus.duty_cur), 100);
    count(256, 1'b1, highs, ticks, ft);
    check("bypass_highs", highs, 100);

    // Disable at cnt=50: finish the period, tick, then idle low
    run_to(50, 1'b1);
    count(206, 1'b0, highs, ticks, ft);
    check("stop_tick_pos", ft, 206);
    count(300, 1'b0, highs, ticks, ft);
    check("idle_highs", highs, 0);
    check("idle_ticks", ticks, 0);

    // Disable at 100, re-enable at 200: same frame, tick still 56 cycles later
    cyc(9'sd0, 1'b0, 1'b1, 1'b0);
    run_to(100, 1'b1);
    run_to(200, 1'b0);
    count(56, 1'b1, highs, ticks, ft);
    check("resume_tick_pos", ft, 56);
    count(256, 1'b1, highs, ticks, ft);
    check("resume_highs", highs, 100);
    check("resume_ticks", ticks, 1);

    // Reset mid-period with pwm high
    run_to(10, 1'b1);
    cyc(9'sd0, 1'b1, 1'b1, 1'b0);
    run_to(255, 1'b1);
    run_to(77, 1'b1);
    check("pre_rst_pwm", int'(bus.pwm_out), 1);
    cyc(9'sd0, 1'b0, 1'b1, 1'b1);
    check("mid_rst_pwm", int'(bus.pwm_out), 0);
    check("mid_rst_duty", int'(bus.duty_cur), 0);
    count(20, 1'b0, highs, ticks, ft);
    check("post_rst_highs", highs, 0);

    // Random traffic against the model
    en = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 299) == 0) en = !en;
      uv  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      cyc(9'($urandom), uv, en, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
